// File: rtl/ps2_defs_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, command bytes, frame helpers.
package ps2_defs;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = S_IDLE,
    ST_INHIBIT   = S_INHIBIT,
    ST_REQ       = S_REQ,
    ST_DATA      = S_DATA,
    ST_ACK       = S_ACK,
    ST_WAIT_IDLE = S_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS  = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
  localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;
  localparam logic [7:0] PS2_RSP_ACK       = 8'hFA;

  // data bits 0-7, parity, stop
  localparam int FRAME_BITS = 10;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus stability filter for one open-drain PS/2 line.
module ps2_line_filter #(
  parameter int clock_filter = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int FW = (clock_filter < 2) ? 1 : $clog2(clock_filter);

  logic [1:0]    sync;
  logic [FW-1:0] cnt;

  // A new level is taken only after clock_filter consecutive differing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == FW'(clock_filter - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + FW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked frame, ACK check.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int clock_filter   = 24,
  parameter int INHIBIT_CYCLES = 10800,
  parameter int SETUP_CYCLES   = 108,
  parameter int TIMEOUT_CYCLES = 1611000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send_trigger,
  input  logic [7:0] send_byte,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_low,
  output logic       ps2_dat_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CW = $clog2(max3(INHIBIT_CYCLES, SETUP_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] INH_LD = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SET_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LD  = CW'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t            state;
  logic [CW-1:0]            cnt;
  logic [3:0]               bit_idx;
  logic [FRAME_BITS-1:0]    frame;
  logic                     ack_ok;
  logic                     clk_lvl, dat_lvl, clk_prev;
  logic                     clk_fall, lines_idle, timed, expire;

  ps2_line_filter #(.clock_filter(clock_filter)) u_clk_filt (
    .clk(clk), .reset_n(reset_n), .raw(ps2_clk_in), .level(clk_lvl)
  );

  ps2_line_filter #(.clock_filter(clock_filter)) u_dat_filt (
    .clk(clk), .reset_n(reset_n), .raw(ps2_dat_in), .level(dat_lvl)
  );

  always_comb begin
    clk_fall   = clk_prev & ~clk_lvl;
    lines_idle = clk_lvl & dat_lvl;
    timed      = (state == ST_DATA) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
    expire     = timed && (cnt == '0) && !clk_fall &&
                 !((state == ST_WAIT_IDLE) && lines_idle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      ack_ok      <= 1'b0;
      clk_prev    <= 1'b1;
      ps2_clk_low <= 1'b0;
      ps2_dat_low <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done     <= 1'b0;
      error    <= 1'b0;
      clk_prev <= clk_lvl;
      if (expire) begin
        // device went silent: let go of both lines and report
        ps2_clk_low <= 1'b0;
        ps2_dat_low <= 1'b0;
        busy        <= 1'b0;
        error       <= 1'b1;
        state       <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (send_trigger) begin
              frame       <= {1'b1, odd_parity(send_byte), send_byte};
              busy        <= 1'b1;
              ps2_clk_low <= 1'b1;
              cnt         <= INH_LD;
              state       <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (cnt == '0) begin
              ps2_dat_low <= 1'b1;
              cnt         <= SET_LD;
              state       <= ST_REQ;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_REQ: begin
            if (cnt == '0) begin
              ps2_clk_low <= 1'b0;
              bit_idx     <= '0;
              cnt         <= TO_LD;
              state       <= ST_DATA;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_DATA: begin
            if (clk_fall) begin
              ps2_dat_low <= ~frame[bit_idx];
              cnt         <= TO_LD;
              if (bit_idx == 4'(FRAME_BITS - 1)) state <= ST_ACK;
              else bit_idx <= bit_idx + 4'd1;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_ACK: begin
            if (clk_fall) begin
              ack_ok <= ~dat_lvl;
              cnt    <= TO_LD;
              state  <= ST_WAIT_IDLE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          ST_WAIT_IDLE: begin
            if (lines_idle) begin
              done  <= ack_ok;
              error <= ~ack_ok;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (clk_fall) begin
              cnt <= TO_LD;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboarded bench for ps2_host_tx with a behavioural PS/2 keyboard on the lines.
module tb_ps2_host_tx;

  localparam int CF  = 16;
  localparam int INH = 200;
  localparam int SET = 20;
  localparam int TO  = 3000;
  localparam int H   = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       send_trigger = 1'b0;
  logic [7:0] send_byte = 8'h00;
  logic       ps2_clk_low, ps2_dat_low, busy, done, error;
  logic       dev_clk_low = 1'b0, dev_dat_low = 1'b0, glitch = 1'b0;
  logic       pin_clk, pin_dat;
  logic [10:0] cap;

  typedef struct {
    bit          edone;
    bit          eerr;
    bit          echk;
    logic [10:0] eframe;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  assign pin_clk = ~(ps2_clk_low | dev_clk_low | glitch);
  assign pin_dat = ~(ps2_dat_low | dev_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .clock_filter(CF), .INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .send_trigger(send_trigger), .send_byte(send_byte),
    .ps2_clk_in(pin_clk), .ps2_dat_in(pin_dat),
    .ps2_clk_low(ps2_clk_low), .ps2_dat_low(ps2_dat_low),
    .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every done/error pulse is matched against the oldest expected outcome
  always @(negedge clk) begin
    if (reset_n && (done || error)) begin
      chk("done_error_exclusive", 32'(done & error), 32'd0);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: done=%0b error=%0b, nothing expected", done, error);
      end else begin
        mon_e = q.pop_front();
        chk("done", 32'(done), 32'(mon_e.edone));
        chk("error", 32'(error), 32'(mon_e.eerr));
        chk("busy_at_pulse", 32'(busy), 32'd0);
        if (mon_e.echk) chk("device_frame", 32'(cap), 32'(mon_e.eframe));
      end
    end
  end

  // keyboard model: clocks npulse falling edges, samples DATA at the end of each low phase
  task automatic run_dev(input int npulse, input bit ack, input int hook);
    cap = '0;
    repeat (50) @(negedge clk);
    cap[0] = pin_dat;
    for (int k = 1; k <= 10 && k <= npulse; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      if (k == npulse && npulse < 10) return;
      cap[k] = pin_dat;
      dev_clk_low = 1'b0;
      if (k == 4 && hook == 1) begin
        send_byte = 8'h55;
        send_trigger = 1'b1;
        @(negedge clk);
        send_trigger = 1'b0;
        repeat (H - 1) @(negedge clk);
      end else if (k == 4 && hook == 2) begin
        repeat (30) @(negedge clk);
        glitch = 1'b1;
        repeat (10) @(negedge clk);
        glitch = 1'b0;
        repeat (H - 40) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    if (npulse > 10) begin
      dev_dat_low = ack;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit push, input bit edone, input bit eerr,
                      input bit echk, input logic [10:0] ef,
                      input int npulse, input bit ack, input int hook);
    exp_t e;
    int k;
    if (push) begin
      e.edone = edone; e.eerr = eerr; e.echk = echk; e.eframe = ef;
      q.push_back(e);
    end
    send_byte = b;
    send_trigger = 1'b1;
    @(negedge clk);
    send_trigger = 1'b0;
    chk("busy_T+1", 32'(busy), 32'd1);
    chk("clk_low_T+1", 32'(ps2_clk_low), 32'd1);
    chk("dat_low_T+1", 32'(ps2_dat_low), 32'd0);
    k = 0;
    while (!ps2_dat_low && k < 2 * INH) begin @(negedge clk); k++; end
    chk("inhibit_len", k, INH);
    k = 0;
    while (ps2_clk_low && k < 2 * SET) begin @(negedge clk); k++; end
    chk("setup_len", k, SET);
    if (npulse == 0) begin
      k = 0;
      while (!error && k < 2 * TO) begin @(negedge clk); k++; end
      chk("timeout_len", k, TO);
      chk("timeout_clk_low", 32'(ps2_clk_low), 32'd0);
      chk("timeout_dat_low", 32'(ps2_dat_low), 32'd0);
    end else begin
      run_dev(npulse, ack, hook);
    end
    if (npulse == 0 || npulse > 10) begin
      k = 0;
      while (busy && k < 2 * TO) begin @(negedge clk); k++; end
      chk("busy_cleared", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_clk_low", 32'(ps2_clk_low), 32'd0);
    chk("rst_dat_low", 32'(ps2_dat_low), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED acked: start0, 1011_0111 LSB first, parity 1, stop 1
    send(8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 11'h7DA, 11, 1'b1, 0);
    // 0x01 nacked: parity 0 on the wire, error after lines idle
    send(8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 11'h402, 11, 1'b0, 0);
    // 0xFF with a silent device: timeout
    send(8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 11'h000, 0, 1'b0, 0);
    // retrigger with 0x55 mid-frame is ignored
    send(8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 11'h7DA, 11, 1'b1, 1);
    chk("retrigger_ignored", 32'(busy), 32'd0);

    // reset while DATA bit 4 is on the wire
    send(8'hED, 1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 5, 1'b1, 0);
    chk("pre_reset_dat_low", 32'(ps2_dat_low), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_clk_low", 32'(ps2_clk_low), 32'd0);
    chk("async_rst_dat_low", 32'(ps2_dat_low), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    send(8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 11'h7DA, 11, 1'b1, 0);

    // 10-cycle CLK glitch is filtered out; 0xF3 parity 1
    send(8'hF3, 1'b1, 1'b1, 1'b0, 1'b1, 11'h7E6, 11, 1'b1, 2);

    repeat (50) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
